// File: rtl/risc8_uart_rx_pkg.sv
// Shared definitions for the risc8 UART receive peripheral: register offsets,
// STATUS bit positions, reset values and the receiver FSM state encoding.
package risc8_uart_rx_pkg;

    localparam logic [6:0] REG_RXDATA = 7'd0;
    localparam logic [6:0] REG_STATUS = 7'd1;
    localparam logic [6:0] REG_BAUD   = 7'd2;

    localparam int STAT_READY   = 0;
    localparam int STAT_OVERRUN = 1;
    localparam int STAT_FERR    = 2;

    localparam logic [7:0] BAUD_RESET = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 deserializer: 2-flop input synchronizer, bit-period counter and
// LSB-first shift register. Emits one-cycle strobes on stop-bit evaluation.
module uart_rx
    import risc8_uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic [7:0] div,
    output logic       rx_strobe,
    output logic [7:0] rx_data,
    output logic       frame_err_strobe,
    output logic [2:0] state
);

    logic      sync1_q, sync2_q;
    logic      rxs;
    rx_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       cnt_zero;

    assign rxs      = sync2_q;
    assign cnt_zero = (cnt_q == 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // The counter free-runs down to zero; every state only acts on zero, so
    // any div value (including 0) always makes progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (!cnt_zero) begin
            cnt_d = cnt_q - 8'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    cnt_d   = {1'b0, div[7:1]};
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_zero) begin
                    if (!rxs) begin
                        cnt_d   = div;
                        bit_d   = 3'd0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_zero) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = div;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_zero) begin
                    state_d = rxs ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                // A break holds the line low; wait for idle so it is not seen as a new start.
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_strobe        = (state_q == ST_STOP) && cnt_zero && rxs;
        frame_err_strobe = (state_q == ST_STOP) && cnt_zero && !rxs;
        rx_data          = shift_q;
        state            = state_q;
    end

endmodule

// File: rtl/risc8_uart_rx.sv
// risc8 UART receive peripheral: RXDATA/STATUS/BAUD registers on the IO bus
// wrapped around the uart_rx deserializer.
module risc8_uart_rx
    import risc8_uart_rx_pkg::*;
#(
    parameter logic [6:0] BASE = 7'h30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ren,
    input  logic       wen,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       valid,
    input  logic       rx_in,
    output logic [2:0] dbg_state
);

    logic [7:0] rxdata_q, rxdata_d;
    logic       rx_ready_q, rx_ready_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] baud_q, baud_d;
    logic [7:0] rdata_q, rdata_d;
    logic       valid_q, valid_d;

    logic       rx_strobe, frame_err_strobe;
    logic [7:0] rx_data;
    logic [6:0] off;
    logic       hit, rd_rxdata, wr_status, wr_baud;
    logic [7:0] status;

    uart_rx u_uart_rx (
        .clk              (clk),
        .reset            (reset),
        .rx_in            (rx_in),
        .div              (baud_q),
        .rx_strobe        (rx_strobe),
        .rx_data          (rx_data),
        .frame_err_strobe (frame_err_strobe),
        .state            (dbg_state)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxdata_q    <= 8'd0;
            rx_ready_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            baud_q      <= BAUD_RESET;
            rdata_q     <= 8'd0;
            valid_q     <= 1'b0;
        end else begin
            rxdata_q    <= rxdata_d;
            rx_ready_q  <= rx_ready_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            baud_q      <= baud_d;
            rdata_q     <= rdata_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        off       = addr - BASE;
        hit       = (off < 7'd3);
        rd_rxdata = ren && (off == REG_RXDATA);
        wr_status = wen && (off == REG_STATUS);
        wr_baud   = wen && (off == REG_BAUD);

        status               = 8'd0;
        status[STAT_READY]   = rx_ready_q;
        status[STAT_OVERRUN] = overrun_q;
        status[STAT_FERR]    = frame_err_q;
    end

    // Clears are applied first so a same-cycle hardware set or delivery wins.
    always_comb begin
        rxdata_d    = rxdata_q;
        rx_ready_d  = rx_ready_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        baud_d      = baud_q;

        if (rd_rxdata) begin
            rx_ready_d = 1'b0;
        end
        if (wr_status) begin
            if (wdata[STAT_OVERRUN]) overrun_d = 1'b0;
            if (wdata[STAT_FERR])    frame_err_d = 1'b0;
        end
        if (wr_baud) begin
            baud_d = wdata;
        end
        if (rx_strobe) begin
            if (!rx_ready_q || rd_rxdata) begin
                rxdata_d   = rx_data;
                rx_ready_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (frame_err_strobe) begin
            frame_err_d = 1'b1;
        end
    end

    always_comb begin
        valid_d = 1'b0;
        rdata_d = rdata_q;
        if (ren && hit) begin
            valid_d = 1'b1;
            case (off)
                REG_RXDATA: rdata_d = rxdata_q;
                REG_STATUS: rdata_d = status;
                default:    rdata_d = baud_q;
            endcase
        end
    end

    assign rdata = rdata_q;
    assign valid = valid_q;

endmodule
